// File: rtl/sram_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sram_bus_arbiter
//  Description : Shares one external SRAM/bus port between the instruction
//                fetch (IF) and data access (MEM) stages. Each access runs
//                through a req/ack handshake. The block raises per-stage
//                stall requests, holds completed read data while a stage is
//                frozen, and drains an in-flight access on flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  if_stall_i,
   input  logic                  mem_stall_i,
   // instruction fetch side
   input  logic                  if_ce_i,
   input  logic [ADDR_W-1:0]     if_addr_i,
   output logic [DATA_W-1:0]     if_data_o,
   output logic                  stallreq_if_o,
   // data access side
   input  logic                  mem_ce_i,
   input  logic                  mem_we_i,
   input  logic [DATA_W/8-1:0]   mem_sel_i,
   input  logic [ADDR_W-1:0]     mem_addr_i,
   input  logic [DATA_W-1:0]     mem_data_i,
   output logic [DATA_W-1:0]     mem_data_o,
   output logic                  stallreq_mem_o,
   // external bus
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [DATA_W/8-1:0]   bus_sel_o,
   output logic [ADDR_W-1:0]     bus_addr_o,
   output logic [DATA_W-1:0]     bus_wdata_o,
   input  logic [DATA_W-1:0]     bus_rdata_i,
   input  logic                  bus_ack_i
);

   localparam int c_sel_w = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IF_BUSY  = 2'd1,
      ST_MEM_BUSY = 2'd2
   } state_e;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_e                state_q;
   logic                  bus_req_q;
   logic                  bus_we_q;
   logic [c_sel_w-1:0]    bus_sel_q;
   logic [ADDR_W-1:0]     bus_addr_q;
   logic [DATA_W-1:0]     bus_wdata_q;
   logic                  discard_q;

   logic                  if_hold_q;
   logic                  if_hold_d;
   logic [DATA_W-1:0]     if_buf_q;
   logic [DATA_W-1:0]     if_buf_d;
   logic                  mem_hold_q;
   logic                  mem_hold_d;
   logic [DATA_W-1:0]     mem_buf_q;
   logic [DATA_W-1:0]     mem_buf_d;

   // ------------------------------------------------------------------------
   // Completion decode: an ack only counts when the access is still wanted,
   // i.e. it was not flushed earlier (discard) nor in the ack cycle itself.
   // ------------------------------------------------------------------------
   logic w_if_done;
   logic w_mem_done;
   logic w_mem_rd_done;
   logic w_mem_cand;
   logic w_if_cand;

   assign w_if_done     = (state_q == ST_IF_BUSY)  & bus_ack_i & ~discard_q & ~flush;
   assign w_mem_done    = (state_q == ST_MEM_BUSY) & bus_ack_i & ~discard_q & ~flush;
   assign w_mem_rd_done = w_mem_done & ~bus_we_q;

   // A stage that is holding buffered data must not start a second access
   // for the same request.
   assign w_mem_cand    = mem_ce_i & ~mem_hold_q & ~flush;
   assign w_if_cand     = if_ce_i  & ~if_hold_q  & ~flush;

   // ------------------------------------------------------------------------
   // Stage-facing outputs
   // ------------------------------------------------------------------------
   assign if_data_o      = if_hold_q  ? if_buf_q  : (w_if_done     ? bus_rdata_i : '0);
   assign mem_data_o     = mem_hold_q ? mem_buf_q : (w_mem_rd_done ? bus_rdata_i : '0);

   // While a flushed access drains, neither stage is told to wait on it.
   assign stallreq_if_o  = if_ce_i  & ~if_hold_q  & ~flush & ~discard_q & ~w_if_done;
   assign stallreq_mem_o = mem_ce_i & ~mem_hold_q & ~flush & ~discard_q & ~w_mem_done;

   assign bus_req_o      = bus_req_q;
   assign bus_we_o       = bus_we_q;
   assign bus_sel_o      = bus_sel_q;
   assign bus_addr_o     = bus_addr_q;
   assign bus_wdata_o    = bus_wdata_q;

   // Next-state of the per-stage hold flags and their data buffers.
   always_comb begin
      if_hold_d  = if_hold_q;
      if_buf_d   = if_buf_q;
      mem_hold_d = mem_hold_q;
      mem_buf_d  = mem_buf_q;

      if (flush) begin
         if_hold_d  = 1'b0;
         mem_hold_d = 1'b0;
      end else begin
         // IF: release one cycle after the stage unfreezes
         if (if_hold_q) begin
            if (!if_stall_i) begin
               if_hold_d = 1'b0;
            end
         end else if (w_if_done && if_stall_i) begin
            if_hold_d = 1'b1;
            if_buf_d  = bus_rdata_i;
         end

         // MEM: a completed write also holds so it is never reissued
         if (mem_hold_q) begin
            if (!mem_stall_i) begin
               mem_hold_d = 1'b0;
            end
         end else if (w_mem_done && mem_stall_i) begin
            mem_hold_d = 1'b1;
            mem_buf_d  = bus_we_q ? '0 : bus_rdata_i;
         end
      end
   end

   // Hold flags and buffers update.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_hold_q  <= 1'b0;
         if_buf_q   <= '0;
         mem_hold_q <= 1'b0;
         mem_buf_q  <= '0;
      end else begin
         if_hold_q  <= if_hold_d;
         if_buf_q   <= if_buf_d;
         mem_hold_q <= mem_hold_d;
         mem_buf_q  <= mem_buf_d;
      end
   end

   // Bus sequencer: grant (MEM first), hold bus signals until ack, then idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         discard_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (w_mem_cand) begin
                  state_q     <= ST_MEM_BUSY;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= mem_we_i;
                  bus_sel_q   <= mem_sel_i;
                  bus_addr_q  <= mem_addr_i;
                  bus_wdata_q <= mem_data_i;
               end else if (w_if_cand) begin
                  state_q     <= ST_IF_BUSY;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= 1'b0;
                  bus_sel_q   <= '1;
                  bus_addr_q  <= if_addr_i;
                  bus_wdata_q <= '0;
               end
            end

            ST_IF_BUSY, ST_MEM_BUSY: begin
               if (bus_ack_i) begin
                  // access finished (or drained); the idle cycle that
                  // follows is the bus turnaround
                  state_q     <= ST_IDLE;
                  bus_req_q   <= 1'b0;
                  bus_we_q    <= 1'b0;
                  bus_sel_q   <= '0;
                  bus_addr_q  <= '0;
                  bus_wdata_q <= '0;
                  discard_q   <= 1'b0;
               end else if (flush) begin
                  discard_q   <= 1'b1;
               end
            end

            default: begin
               state_q   <= ST_IDLE;
               bus_req_q <= 1'b0;
               discard_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bus_arbiter
//  Description : Randomised bench for sram_bus_arbiter. A transaction-level
//                model predicts every cycle's outputs; predictions are queued
//                and a separate monitor compares them against the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int SW     = DW / 8;
   localparam int NCYC   = 4000;

   logic          clk = 1'b0;
   logic          rst, flush, if_stall_i, mem_stall_i;
   logic          if_ce_i, mem_ce_i, mem_we_i;
   logic [AW-1:0] if_addr_i, mem_addr_i;
   logic [SW-1:0] mem_sel_i;
   logic [DW-1:0] mem_data_i, bus_rdata_i;
   logic          bus_ack_i;
   logic [DW-1:0] if_data_o, mem_data_o, bus_wdata_o;
   logic          stallreq_if_o, stallreq_mem_o, bus_req_o, bus_we_o;
   logic [SW-1:0] bus_sel_o;
   logic [AW-1:0] bus_addr_o;

   always #5 clk = ~clk;

   sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .if_stall_i     (if_stall_i),
      .mem_stall_i    (mem_stall_i),
      .if_ce_i        (if_ce_i),
      .if_addr_i      (if_addr_i),
      .if_data_o      (if_data_o),
      .stallreq_if_o  (stallreq_if_o),
      .mem_ce_i       (mem_ce_i),
      .mem_we_i       (mem_we_i),
      .mem_sel_i      (mem_sel_i),
      .mem_addr_i     (mem_addr_i),
      .mem_data_i     (mem_data_i),
      .mem_data_o     (mem_data_o),
      .stallreq_mem_o (stallreq_mem_o),
      .bus_req_o      (bus_req_o),
      .bus_we_o       (bus_we_o),
      .bus_sel_o      (bus_sel_o),
      .bus_addr_o     (bus_addr_o),
      .bus_wdata_o    (bus_wdata_o),
      .bus_rdata_i    (bus_rdata_i),
      .bus_ack_i      (bus_ack_i)
   );

   // expected view of one cycle
   typedef struct {
      int            cyc;
      logic [DW-1:0] if_data;
      logic [DW-1:0] mem_data;
      logic          st_if;
      logic          st_mem;
      logic          req;
      logic          we;
      logic [SW-1:0] sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // transaction-level model: one optional outstanding access plus per-stage
   // "result parked" flags
   bit            t_live;      // an access owns the bus
   bit            t_mem;       // owner is MEM (else IF)
   bit            t_we;
   logic [SW-1:0] t_sel;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wdata;
   bit            t_dropped;   // flushed, result will be thrown away
   bit            park_if, park_mem;
   logic [DW-1:0] park_if_val, park_mem_val;

   task automatic model_reset();
      t_live = 0; t_mem = 0; t_we = 0; t_sel = '0; t_addr = '0; t_wdata = '0;
      t_dropped = 0; park_if = 0; park_mem = 0; park_if_val = '0; park_mem_val = '0;
   endtask

   task automatic chk(input string name, input int cyc, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // monitor: compare one predicted cycle per falling edge
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk("if_data",      e.cyc, 64'(if_data_o),      64'(e.if_data));
         chk("mem_data",     e.cyc, 64'(mem_data_o),     64'(e.mem_data));
         chk("stallreq_if",  e.cyc, 64'(stallreq_if_o),  64'(e.st_if));
         chk("stallreq_mem", e.cyc, 64'(stallreq_mem_o), 64'(e.st_mem));
         chk("bus_req",      e.cyc, 64'(bus_req_o),      64'(e.req));
         chk("bus_we",       e.cyc, 64'(bus_we_o),       64'(e.we));
         chk("bus_sel",      e.cyc, 64'(bus_sel_o),      64'(e.sel));
         chk("bus_addr",     e.cyc, 64'(bus_addr_o),     64'(e.addr));
         chk("bus_wdata",    e.cyc, 64'(bus_wdata_o),    64'(e.wdata));
      end
   end

   // stimulus + prediction
   initial begin
      exp_t e;
      bit   acked, usable, if_fin, mem_fin;
      bit   n_park_if, n_park_mem;
      logic [DW-1:0] n_park_if_val, n_park_mem_val;

      rst = 1; flush = 0; if_stall_i = 0; mem_stall_i = 0;
      if_ce_i = 0; mem_ce_i = 0; mem_we_i = 0; mem_sel_i = '0;
      if_addr_i = '0; mem_addr_i = '0; mem_data_i = '0;
      bus_rdata_i = '0; bus_ack_i = 0;
      model_reset();
      repeat (2) @(posedge clk);

      for (int i = 0; i < NCYC; i++) begin
         @(posedge clk);
         #1;
         rst         = (i < 2) || ($urandom_range(0, 199) < 3);
         flush       = ($urandom_range(0, 99) < 6);
         if_ce_i     = ($urandom_range(0, 99) < 70);
         mem_ce_i    = ($urandom_range(0, 99) < 40);
         mem_we_i    = $urandom_range(0, 1) == 1;
         mem_sel_i   = SW'($urandom);
         if_addr_i   = $urandom;
         mem_addr_i  = $urandom;
         mem_data_i  = $urandom;
         if_stall_i  = ($urandom_range(0, 99) < 35);
         mem_stall_i = ($urandom_range(0, 99) < 35);
         bus_rdata_i = $urandom;
         // bus slave: random latency; occasional stray ack while idle
         bus_ack_i   = t_live ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);

         // outputs this cycle
         acked   = t_live && bus_ack_i;
         usable  = acked && !t_dropped && !flush;
         if_fin  = usable && !t_mem;
         mem_fin = usable && t_mem;

         e.cyc      = i;
         e.if_data  = park_if  ? park_if_val  : (if_fin ? bus_rdata_i : '0);
         e.mem_data = park_mem ? park_mem_val : ((mem_fin && !t_we) ? bus_rdata_i : '0);
         e.st_if    = if_ce_i  && !park_if  && !flush && !t_dropped && !if_fin;
         e.st_mem   = mem_ce_i && !park_mem && !flush && !t_dropped && !mem_fin;
         e.req      = t_live;
         e.we       = t_live ? t_we    : 1'b0;
         e.sel      = t_live ? t_sel   : '0;
         e.addr     = t_live ? t_addr  : '0;
         e.wdata    = t_live ? t_wdata : '0;
         sb_q.push_back(e);

         // state after the coming clock edge
         if (rst) begin
            model_reset();
         end else begin
            n_park_if = park_if;  n_park_if_val  = park_if_val;
            n_park_mem = park_mem; n_park_mem_val = park_mem_val;
            if (flush) begin
               n_park_if = 0; n_park_mem = 0;
            end else begin
               if (park_if) n_park_if = if_stall_i;
               else if (if_fin && if_stall_i) begin
                  n_park_if = 1; n_park_if_val = bus_rdata_i;
               end
               if (park_mem) n_park_mem = mem_stall_i;
               else if (mem_fin && mem_stall_i) begin
                  n_park_mem = 1; n_park_mem_val = t_we ? '0 : bus_rdata_i;
               end
            end

            if (t_live) begin
               if (bus_ack_i) begin
                  t_live = 0; t_dropped = 0;
               end else if (flush) begin
                  t_dropped = 1;
               end
            end else if (!flush) begin
               if (mem_ce_i && !park_mem) begin
                  t_live = 1; t_mem = 1; t_we = mem_we_i; t_sel = mem_sel_i;
                  t_addr = mem_addr_i; t_wdata = mem_data_i;
               end else if (if_ce_i && !park_if) begin
                  t_live = 1; t_mem = 0; t_we = 0; t_sel = '1;
                  t_addr = if_addr_i; t_wdata = '0;
               end
            end

            park_if = n_park_if;  park_if_val  = n_park_if_val;
            park_mem = n_park_mem; park_mem_val = n_park_mem_val;
         end
      end

      repeat (3) @(posedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
